// File: rtl/pipe_ctrl.sv
// D-stage decoder and E-stage control register for an RV32I(M) pipeline,
// with a small IDLE/BUSY sequencer that holds F/D while a MUL/DIV occupies E.
module pipe_ctrl #(
  parameter bit M_EXT   = 1'b1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_d,
  input  logic        valid_d,
  input  logic        stall_in,
  input  logic        flush_e,
  output logic        stall_d,
  output logic        valid_e,
  output logic        illegal_e,
  output logic        reg_wr_e,
  output logic        sel_a_e,
  output logic        sel_b_e,
  output logic [1:0]  wb_sel_e,
  output logic [2:0]  imm_src_e,
  output logic [2:0]  funct3_e,
  output logic [4:0]  alu_op_e,
  output logic [6:0]  opcode_e,
  output logic        md_busy,
  output logic        md_done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;

  localparam logic [4:0] A_ADD = 5'd0,  A_SUB = 5'd1,  A_SLL = 5'd2,  A_SLT = 5'd3;
  localparam logic [4:0] A_SLTU = 5'd4, A_XOR = 5'd5,  A_SRL = 5'd6,  A_SRA = 5'd7;
  localparam logic [4:0] A_OR = 5'd8,   A_AND = 5'd9,  A_LUI = 5'd10, A_MUL = 5'd11;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_wr;
    logic       sel_a;
    logic       sel_b;
    logic [1:0] wb_sel;
    logic [2:0] imm_src;
    logic [2:0] funct3;
    logic [4:0] alu_op;
    logic [6:0] opcode;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;
  assign op = inst_d[6:0];
  assign f3 = inst_d[14:12];
  assign f7 = inst_d[31:25];
  assign unused_fields = ^{inst_d[24:15], inst_d[11:7]};

  ctrl_t  dec;
  logic   is_md;
  logic [4:0] base_op;

  // funct3 maps straight onto the ALU op for the register/immediate forms.
  always_comb begin
    base_op = A_ADD;
    case (f3)
      3'b000: base_op = A_ADD;
      3'b001: base_op = A_SLL;
      3'b010: base_op = A_SLT;
      3'b011: base_op = A_SLTU;
      3'b100: base_op = A_XOR;
      3'b101: base_op = A_SRL;
      3'b110: base_op = A_OR;
      3'b111: base_op = A_AND;
      default: base_op = A_ADD;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.funct3 = f3;
    dec.opcode = op;
    is_md      = 1'b0;
    case (op)
      OP_R: begin
        dec.reg_wr = 1'b1; dec.sel_a = 1'b1; dec.wb_sel = 2'b01;
        if (f7 == 7'b0000000)                      dec.alu_op = base_op;
        else if (f7 == 7'b0100000 && f3 == 3'b000) dec.alu_op = A_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) dec.alu_op = A_SRA;
        else if (f7 == 7'b0000001 && M_EXT) begin
          is_md      = 1'b1;
          dec.alu_op = A_MUL + {2'b00, f3};
        end
        else dec.illegal = 1'b1;
      end
      OP_I: begin
        dec.reg_wr = 1'b1; dec.sel_a = 1'b1; dec.sel_b = 1'b1; dec.wb_sel = 2'b01;
        dec.alu_op = base_op;
        if (f3 == 3'b001 && f7 != 7'b0000000) dec.illegal = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      dec.alu_op  = A_SRA;
          else if (f7 != 7'b0000000) dec.illegal = 1'b1;
        end
      end
      OP_LD:  begin dec.reg_wr = 1'b1; dec.sel_a = 1'b1; dec.sel_b = 1'b1; dec.wb_sel = 2'b10; end
      OP_ST:  begin dec.sel_a = 1'b1; dec.sel_b = 1'b1; dec.imm_src = 3'b001; end
      OP_LUI: begin
        dec.reg_wr = 1'b1; dec.sel_b = 1'b1; dec.wb_sel = 2'b01;
        dec.imm_src = 3'b100; dec.alu_op = A_LUI;
      end
      OP_AUI: begin dec.reg_wr = 1'b1; dec.sel_b = 1'b1; dec.wb_sel = 2'b01; dec.imm_src = 3'b100; end
      OP_BR:  begin dec.sel_b = 1'b1; dec.imm_src = 3'b010; end
      OP_JAL: begin dec.reg_wr = 1'b1; dec.sel_b = 1'b1; dec.imm_src = 3'b011; end
      OP_JLR: begin dec.reg_wr = 1'b1; dec.sel_a = 1'b1; dec.sel_b = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal encodings must never write back or look like a multi-cycle op.
    if (dec.illegal) begin
      dec.reg_wr = 1'b0;
      dec.wb_sel = 2'b00;
      dec.alu_op = A_ADD;
      is_md      = 1'b0;
    end
    dec.valid = valid_d;
  end

  ctrl_t         e_q, e_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy, cnt_nz;

  assign busy    = (state_q == BUSY);
  assign cnt_nz  = (cnt_q != '0);
  assign stall_d = stall_in | (busy & cnt_nz);
  assign md_busy = busy;
  assign md_done = busy & ~cnt_nz & ~flush_e;

  always_comb begin
    e_d     = e_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_e) begin
      e_d     = '0;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (busy && cnt_nz) cnt_d = cnt_q - CW'(1);
      if (!stall_d) begin
        e_d = dec;
        if (valid_d && is_md) begin
          state_d = BUSY;
          cnt_d   = f3[2] ? DIV_LD : MUL_LD;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q     <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_e   = e_q.valid;
  assign illegal_e = e_q.illegal;
  assign reg_wr_e  = e_q.reg_wr;
  assign sel_a_e   = e_q.sel_a;
  assign sel_b_e   = e_q.sel_b;
  assign wb_sel_e  = e_q.wb_sel;
  assign imm_src_e = e_q.imm_src;
  assign funct3_e  = e_q.funct3;
  assign alu_op_e  = e_q.alu_op;
  assign opcode_e  = e_q.opcode;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: decode vectors, MUL/DIV stall sequencing,
// flush/reset aborts, and an M_EXT=0 instance for illegal M encodings.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, valid_d, stall_in, flush_e;
  logic [31:0] inst_d;

  logic       stall_d, valid_e, illegal_e, reg_wr_e, sel_a_e, sel_b_e, md_busy, md_done;
  logic [1:0] wb_sel_e;
  logic [2:0] imm_src_e, funct3_e;
  logic [4:0] alu_op_e;
  logic [6:0] opcode_e;

  logic       m0_stall_d, m0_valid_e, m0_illegal_e, m0_reg_wr_e, m0_sel_a_e, m0_sel_b_e;
  logic       m0_md_busy, m0_md_done;
  logic [1:0] m0_wb_sel_e;
  logic [2:0] m0_imm_src_e, m0_funct3_e;
  logic [4:0] m0_alu_op_e;
  logic [6:0] m0_opcode_e;

  int vecs = 0;
  int errs = 0;
  int stalls, dones;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h0000A283;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;

  pipe_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .valid_d(valid_d),
    .stall_in(stall_in), .flush_e(flush_e), .stall_d(stall_d),
    .valid_e(valid_e), .illegal_e(illegal_e), .reg_wr_e(reg_wr_e),
    .sel_a_e(sel_a_e), .sel_b_e(sel_b_e), .wb_sel_e(wb_sel_e),
    .imm_src_e(imm_src_e), .funct3_e(funct3_e), .alu_op_e(alu_op_e),
    .opcode_e(opcode_e), .md_busy(md_busy), .md_done(md_done)
  );

  pipe_ctrl #(.M_EXT(1'b0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .valid_d(valid_d),
    .stall_in(stall_in), .flush_e(flush_e), .stall_d(m0_stall_d),
    .valid_e(m0_valid_e), .illegal_e(m0_illegal_e), .reg_wr_e(m0_reg_wr_e),
    .sel_a_e(m0_sel_a_e), .sel_b_e(m0_sel_b_e), .wb_sel_e(m0_wb_sel_e),
    .imm_src_e(m0_imm_src_e), .funct3_e(m0_funct3_e), .alu_op_e(m0_alu_op_e),
    .opcode_e(m0_opcode_e), .md_busy(m0_md_busy), .md_done(m0_md_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_d = 1'b0; stall_in = 1'b1; flush_e = 1'b0; inst_d = I_ADD;
    tick(); tick();
    chk("rst_valid", valid_e, 0);
    chk("rst_regwr", reg_wr_e, 0);
    chk("rst_opcode", opcode_e, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_stall_in", stall_d, 1);
    stall_in = 1'b0; #1;
    chk("rst_stall_clr", stall_d, 0);

    // add
    rst_n = 1'b1; valid_d = 1'b1; inst_d = I_ADD;
    tick();
    chk("add_valid", valid_e, 1);
    chk("add_regwr", reg_wr_e, 1);
    chk("add_sela", sel_a_e, 1);
    chk("add_selb", sel_b_e, 0);
    chk("add_wb", wb_sel_e, 2'b01);
    chk("add_alu", alu_op_e, 5'b00000);
    chk("add_opc", opcode_e, 7'b0110011);
    chk("add_ill", illegal_e, 0);
    chk("add_stall", stall_d, 0);

    inst_d = I_LW; tick();
    chk("lw_wb", wb_sel_e, 2'b10);
    chk("lw_selb", sel_b_e, 1);
    chk("lw_imm", imm_src_e, 3'b000);
    chk("lw_alu", alu_op_e, 5'b00000);
    chk("lw_f3", funct3_e, 3'b010);

    inst_d = 32'hFFFFFFFF; tick();
    chk("ff_ill", illegal_e, 1);
    chk("ff_regwr", reg_wr_e, 0);
    chk("ff_wb", wb_sel_e, 0);
    chk("ff_valid", valid_e, 1);

    inst_d = 32'h402081B3; tick();
    chk("sub_alu", alu_op_e, 5'b00001);
    chk("sub_ill", illegal_e, 0);

    inst_d = 32'h402091B3; tick();
    chk("r_bad_f7_ill", illegal_e, 1);
    chk("r_bad_f7_alu", alu_op_e, 0);

    inst_d = 32'h4030D193; tick();
    chk("srai_alu", alu_op_e, 5'b00111);
    chk("srai_ill", illegal_e, 0);
    chk("srai_selb", sel_b_e, 1);

    inst_d = 32'h40309193; tick();
    chk("slli_bad_ill", illegal_e, 1);

    inst_d = 32'h0020A223; tick();
    chk("sw_regwr", reg_wr_e, 0);
    chk("sw_imm", imm_src_e, 3'b001);

    inst_d = 32'h008000EF; tick();
    chk("jal_wb", wb_sel_e, 2'b00);
    chk("jal_imm", imm_src_e, 3'b011);
    chk("jal_sela", sel_a_e, 0);
    chk("jal_regwr", reg_wr_e, 1);

    inst_d = 32'h123451B7; tick();
    chk("lui_alu", alu_op_e, 5'b01010);
    chk("lui_imm", imm_src_e, 3'b100);

    inst_d = 32'h00208463; tick();
    chk("beq_regwr", reg_wr_e, 0);
    chk("beq_imm", imm_src_e, 3'b010);

    // external stall holds E
    stall_in = 1'b1; inst_d = I_ADD; #1;
    chk("hold_stall", stall_d, 1);
    tick();
    chk("hold_opc", opcode_e, 7'b1100011);
    stall_in = 1'b0;

    valid_d = 1'b0; tick();
    chk("bubble_valid", valid_e, 0);
    valid_d = 1'b1;

    // MUL, 2-cycle occupancy
    inst_d = I_MUL; tick();
    chk("mul_alu", alu_op_e, 5'b01011);
    chk("mul_busy", md_busy, 1);
    chk("m0_mul_ill", m0_illegal_e, 1);
    chk("m0_mul_regwr", m0_reg_wr_e, 0);
    chk("m0_mul_busy", m0_md_busy, 0);
    inst_d = I_ADD; #1;
    chk("mul_c1_stall", stall_d, 1);
    chk("mul_c1_done", md_done, 0);
    tick();
    chk("mul_c2_alu", alu_op_e, 5'b01011);
    chk("mul_c2_stall", stall_d, 0);
    chk("mul_c2_done", md_done, 1);
    tick();
    chk("mul_next_alu", alu_op_e, 5'b00000);
    chk("mul_next_busy", md_busy, 0);
    chk("mul_next_done", md_done, 0);

    // MUL completion held by external stall
    inst_d = I_MUL; tick();
    inst_d = I_ADD; tick();
    stall_in = 1'b1; #1;
    chk("mulh_done", md_done, 1);
    chk("mulh_stall", stall_d, 1);
    tick();
    chk("mulh_done2", md_done, 1);
    chk("mulh_alu2", alu_op_e, 5'b01011);
    stall_in = 1'b0; tick();
    chk("mulh_rel_alu", alu_op_e, 5'b00000);
    chk("mulh_rel_done", md_done, 0);

    // DIV, 32-cycle occupancy
    inst_d = I_DIV; tick();
    chk("div_alu", alu_op_e, 5'b01111);
    inst_d = I_ADD;
    stalls = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (stall_d) stalls++;
      if (md_done) dones++;
      tick();
    end
    chk("div_stalls", stalls, 31);
    chk("div_dones", dones, 1);
    chk("div_after_busy", md_busy, 0);

    // DIV flushed at E cycle 10
    inst_d = I_DIV; tick();
    inst_d = I_ADD;
    for (int i = 0; i < 9; i++) tick();
    chk("divf_busy", md_busy, 1);
    flush_e = 1'b1; #1;
    chk("divf_done_fl", md_done, 0);
    tick();
    flush_e = 1'b0;
    chk("divf_valid", valid_e, 0);
    chk("divf_alu", alu_op_e, 0);
    chk("divf_busy_clr", md_busy, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) dones++;
      tick();
    end
    chk("divf_no_done", dones, 0);

    // reset during DIV
    inst_d = I_DIV; tick();
    inst_d = I_ADD;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0; tick();
    chk("divr_valid", valid_e, 0);
    chk("divr_alu", alu_op_e, 0);
    chk("divr_opc", opcode_e, 0);
    chk("divr_f3", funct3_e, 0);
    chk("divr_busy", md_busy, 0);
    chk("divr_done", md_done, 0);
    chk("divr_stall", stall_d, 0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) dones++;
      tick();
    end
    chk("divr_no_done", dones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  M_EXT    1   1 = decode RV32M (MUL/DIV family); 0 = RV32M encodings flagged illegal
  MUL_LAT  2   E-stage occupancy in cycles for MUL/MULH/MULHSU/MULHU; legal range >=1
  DIV_LAT  32  E-stage occupancy in cycles for DIV/DIVU/REM/REMU; legal range >=1
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk        in   1   single clock, rising edge
  rst_n      in   1   reset, synchronous, active-low
  inst_d     in   32  D-stage instruction
  valid_d    in   1   inst_d holds a real instruction
  stall_in   in   1   external hazard hold request
  flush_e    in   1   kill E-stage contents (taken branch/jump)
  stall_d    out  1   hold F/D stages this cycle
  valid_e    out  1   E register holds a live instruction
  illegal_e  out  1   E instruction is an illegal encoding
  reg_wr_e   out  1   register-file write enable
  sel_a_e    out  1   ALU A: 1 = rs1, 0 = PC
  sel_b_e    out  1   ALU B: 1 = immediate, 0 = rs2
  wb_sel_e   out  2   00 = PC+4, 01 = ALU, 10 = load data
  imm_src_e  out  3   000 I, 001 S, 010 B, 011 J, 100 U
  funct3_e   out  3   inst[14:12]
  alu_op_e   out  5   ALU/MD operation code
  opcode_e   out  7   inst[6:0]
  md_busy    out  1   multi-cycle MUL/DIV in progress
  md_done    out  1   one-cycle pulse, MUL/DIV result valid this cycle

Function
REQ-003 SHALL decode inst_d combinationally and register all *_e outputs; D-to-E latency is one cycle.
REQ-004 SHALL use alu_op codes: ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001, LUI 01010, MUL 01011, MULH 01100, MULHSU 01101, MULHU 01110, DIV 01111, DIVU 10000, REM 10001, REMU 10010.
REQ-005 SHALL decode R, I-ALU, load, store, LUI, AUIPC, branch, JAL, JALR with the control values in REQ-002 meanings; loads/stores/AUIPC/branch/JAL/JALR use ADD; branch/store reg_wr=0.
REQ-006 SHALL drive every control with a defined value (no X); unused fields are 0.
REQ-007 SHALL set illegal=1 for: unknown opcode; R-type funct7 not in {0000000, 0100000 with funct3 000/101, 0000001 when M_EXT=1}; I-type shift funct7 invalid (0100000 only with funct3 101).
REQ-008 SHALL force reg_wr=0, wb_sel=00, alu_op=ADD for illegal instructions; valid_e still follows valid_d.
REQ-009 SHALL update the E register per cycle with priority: rst_n=0 clear; flush_e=1 clear (valid_e=0, all controls 0); stall_d=1 hold; else capture decode with valid_e=valid_d.
REQ-010 SHALL implement FSM IDLE/BUSY; capture of a valid M instruction goes to BUSY with cnt = LAT-1 (MUL_LAT if funct3[2]=0, else DIV_LAT), cnt width clog2(max(MUL_LAT,DIV_LAT))+1.
REQ-011 SHALL in BUSY: md_busy=1; stall_d = stall_in | (cnt!=0); decrement cnt when nonzero; md_done=1 when cnt==0, next state IDLE unless a new M instruction is captured that same cycle (then reload per REQ-010).
REQ-012 SHALL in IDLE: md_busy=0, md_done=0, stall_d=stall_in.
REQ-013 SHALL, on flush_e in BUSY, return to IDLE next cycle with no md_done; flush_e beats stall_in and md stall.
REQ-014 SHALL hold cnt unchanged while stall_in=1 with cnt==0 (md_done stays high until release, then one capture).

Reset
REQ-015 SHALL, on rst_n low at a clock edge, set FSM IDLE, cnt 0, valid_e 0, illegal_e 0, all *_e controls 0, md_busy 0, md_done 0; stall_d = stall_in.
REQ-016 SHALL abort any BUSY operation on reset with no md_done pulse.

Verification
REQ-017 add 0x002081B3 valid -> next cycle reg_wr_e=1, sel_a_e=1, sel_b_e=0, wb_sel_e=01, alu_op_e=00000, stall_d=0.
REQ-018 lw 0x0000A283 -> wb_sel_e=10, sel_b_e=1, imm_src_e=000, alu_op_e=00000; 0xFFFFFFFF -> illegal_e=1, reg_wr_e=0.
REQ-019 mul 0x022081B3, MUL_LAT=2 -> alu_op_e=01011, stall_d=1 one cycle, md_done on 2nd E cycle, then next instruction captured.
REQ-020 div 0x0220C1B3, DIV_LAT=32 -> stall_d high 31 cycles, md_done once; flush_e at cycle 10 -> IDLE, valid_e=0, no md_done.
REQ-021 M_EXT=0, mul 0x022081B3 -> illegal_e=1, md_busy stays 0; rst_n low mid-DIV -> all outputs 0 next cycle.
